branch_predictor: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage pipeline; replaces static predict-not-taken.
//  IF looks up PC_out combinationally to get a predicted target.
//  EX reports the resolved outcome one update per cycle: BTB and counter tables are trained.

---
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a table of saturating
// counters, indexed either bimodally or gshare-style (PC XOR global history).
// IF gets a zero-latency prediction; EX trains the tables with one resolved
// branch per cycle and repairs the global history on a mispredict.
//
// Handshake: there is no back-pressure. lu_valid marks a real fetch and only
// gates the history shift; upd_valid qualifies every upd_* input for exactly
// one cycle and upd_* are ignored whenever it is low.
module branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 8,
    parameter int PHT_ENTRIES = 256,
    parameter int CNT_W       = 2,
    parameter int GSHARE      = 0,
    parameter int HIST_W      = 6,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lu_valid,
    input  logic [31:0]       lu_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_mispredict,
    input  logic              inv,
    output logic [STAT_W-1:0] mispred_cnt
);
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int PI = $clog2(PHT_ENTRIES);
    // Weakly not-taken: MSB clear, every lower bit set.
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [29:0]            btb_target [BTB_ENTRIES];
    logic [CNT_W-1:0]       pht        [PHT_ENTRIES];
    logic [HIST_W-1:0]      ghr;

    logic [BI-1:0]    lu_bi, upd_bi;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic [PI-1:0]    lu_hist, upd_hist, lu_pi, upd_pi;
    logic [CNT_W-1:0] lu_cnt, upd_cnt;
    logic             hit;
    logic             unused_bits;

    // Shift one outcome into a history value; works for HIST_W == 1 as well.
    function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] h,
                                                     input logic b);
        logic [HIST_W:0] t;
        t = {h, b};
        return t[HIST_W-1:0];
    endfunction

    // Zero-extend history to the counter-table index width (zero in bimodal mode).
    always_comb begin
        lu_hist  = '0;
        upd_hist = '0;
        if (GSHARE != 0) begin
            lu_hist[HIST_W-1:0]  = ghr;
            upd_hist[HIST_W-1:0] = upd_ghr;
        end
    end

    assign lu_bi   = lu_pc[BI+1:2];
    assign lu_tag  = lu_pc[BI+TAG_W+1:BI+2];
    assign lu_pi   = lu_pc[PI+1:2] ^ lu_hist;
    assign upd_bi  = upd_pc[BI+1:2];
    assign upd_tag = upd_pc[BI+TAG_W+1:BI+2];
    assign upd_pi  = upd_pc[PI+1:2] ^ upd_hist;

    assign hit    = btb_valid[lu_bi] && (btb_tag[lu_bi] == lu_tag);
    assign lu_cnt = pht[lu_pi];
    assign upd_cnt = pht[upd_pi];

    assign pred_hit    = hit;
    assign pred_taken  = hit && lu_cnt[CNT_W-1];
    assign pred_target = hit ? {btb_target[lu_bi], 2'b00} : 32'h0;
    assign pred_ghr    = ghr;

    // Address bits that neither index nor tag anything.
    assign unused_bits = ^{lu_pc[1:0], lu_pc[31:BI+TAG_W+2],
                           upd_pc[1:0], upd_pc[31:BI+TAG_W+2], upd_target[1:0]};

    // BTB valid bits: invalidate wins over a same-cycle taken write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
        end else if (inv) begin
            btb_valid <= '0;
        end else if (upd_valid && upd_taken) begin
            btb_valid[upd_bi] <= 1'b1;
        end
    end

    // BTB payload: harmless to write under inv because the entry stays invalid.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[upd_bi]    <= upd_tag;
            btb_target[upd_bi] <= upd_target[31:2];
        end
    end

    // Counter table: saturating up on taken, down on not-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_INIT;
        end else if (upd_valid) begin
            if (upd_taken && upd_cnt != CNT_MAX) begin
                pht[upd_pi] <= upd_cnt + CNT_W'(1);
            end else if (!upd_taken && upd_cnt != '0) begin
                pht[upd_pi] <= upd_cnt - CNT_W'(1);
            end
        end
    end

    // Global history: mispredict repair beats speculative shift on a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (GSHARE == 0) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispredict) begin
            ghr <= shift_hist(upd_ghr, upd_taken);
        end else if (lu_valid && hit) begin
            ghr <= shift_hist(ghr, pred_taken);
        end
    end

    // Mispredict statistic, sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispred_cnt <= '0;
        end else if (upd_valid && upd_mispredict && mispred_cnt != {STAT_W{1'b1}}) begin
            mispred_cnt <= mispred_cnt + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance (defaults) and a gshare instance with a
// 2-bit statistic counter, sharing clock and reset.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Bimodal instance signals
    logic        lu_valid, pred_hit, pred_taken;
    logic [31:0] lu_pc, pred_target;
    logic [5:0]  pred_ghr;
    logic        upd_valid, upd_taken, upd_mispredict, inv;
    logic [31:0] upd_pc, upd_target;
    logic [5:0]  upd_ghr;
    logic [15:0] mispred_cnt;

    // Gshare instance signals
    logic        g_lu_valid, g_pred_hit, g_pred_taken;
    logic [31:0] g_lu_pc, g_pred_target;
    logic [5:0]  g_pred_ghr;
    logic        g_upd_valid, g_upd_taken, g_upd_mispredict, g_inv;
    logic [31:0] g_upd_pc, g_upd_target;
    logic [5:0]  g_upd_ghr;
    logic [1:0]  g_mispred_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    localparam logic [31:0] PC_P = 32'h0040_0010;
    localparam logic [31:0] TG_P = 32'h0040_0040;
    localparam logic [31:0] PC_A = 32'h0040_1010;
    localparam logic [31:0] TG_A = 32'h0040_1080;
    localparam logic [31:0] PC_Q = 32'h0040_0800;

    branch_predictor dut (
        .clk(clk), .reset(reset),
        .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict), .inv(inv),
        .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.GSHARE(1), .HIST_W(6), .STAT_W(2)) dut_g (
        .clk(clk), .reset(reset),
        .lu_valid(g_lu_valid), .lu_pc(g_lu_pc),
        .pred_hit(g_pred_hit), .pred_taken(g_pred_taken),
        .pred_target(g_pred_target), .pred_ghr(g_pred_ghr),
        .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_taken(g_upd_taken),
        .upd_target(g_upd_target), .upd_ghr(g_upd_ghr),
        .upd_mispredict(g_upd_mispredict), .inv(g_inv),
        .mispred_cnt(g_mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_idle();
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_ghr = 0; upd_mispredict = 0; inv = 0;
    endtask

    task automatic g_idle();
        g_upd_valid = 0; g_upd_pc = 0; g_upd_taken = 0; g_upd_target = 0;
        g_upd_ghr = 0; g_upd_mispredict = 0; g_inv = 0;
    endtask

    task automatic a_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic misp);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_ghr = 0; upd_mispredict = misp;
    endtask

    task automatic g_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [5:0] gh, input logic misp);
        g_upd_valid = 1; g_upd_pc = pc; g_upd_taken = tk; g_upd_target = tgt;
        g_upd_ghr = gh; g_upd_mispredict = misp;
    endtask

    // n identical updates on the bimodal instance, one per cycle
    task automatic a_train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input int n);
        for (int i = 0; i < n; i++) begin
            a_upd(pc, tk, tgt, 1'b0);
            @(negedge clk);
        end
        a_idle();
    endtask

    initial begin
        reset = 0;
        a_idle(); g_idle();
        lu_valid = 1; lu_pc = PC_P;
        g_lu_valid = 0; g_lu_pc = PC_P;
        repeat (2) @(negedge clk);
        check("rst_hit", pred_hit, 0);
        check("rst_ghr_g", g_pred_ghr, 0);
        reset = 1;
        @(negedge clk);

        // Test 1: fresh lookup misses
        #1;
        check("t1_hit", pred_hit, 0);
        check("t1_taken", pred_taken, 0);
        check("t1_target", pred_target, 0);
        check("t1_cnt", mispred_cnt, 0);

        // Test 2: taken update, not visible until next cycle
        a_upd(PC_P, 1, TG_P, 0);
        #1 check("t2_same_cycle_hit", pred_hit, 0);
        @(negedge clk); a_idle();
        #1;
        check("t2_hit", pred_hit, 1);
        check("t2_taken", pred_taken, 1);
        check("t2_target", pred_target, TG_P);
        check("t2_ghr_bimodal", pred_ghr, 0);

        // Test 3: saturation (counter is 2 here)
        a_train(PC_P, 1, TG_P, 4);
        a_train(PC_P, 0, TG_P, 1);
        #1 check("t3_one_nt_taken", pred_taken, 1);
        a_train(PC_P, 0, TG_P, 1);
        #1 check("t3_two_nt_taken", pred_taken, 0);
        check("t3_two_nt_hit", pred_hit, 1);
        a_train(PC_P, 0, TG_P, 10);
        #1 check("t3_floor_taken", pred_taken, 0);
        a_train(PC_P, 1, TG_P, 1);
        #1 check("t3_no_wrap_taken", pred_taken, 0);
        a_train(PC_P, 1, TG_P, 1);
        #1 check("t3_back_up_taken", pred_taken, 1);

        // Test 4: alias in the same BTB set
        lu_pc = PC_A;
        #1 check("t4_alias_hit", pred_hit, 0);
        check("t4_alias_target", pred_target, 0);
        check("t4_alias_taken", pred_taken, 0);
        a_train(PC_A, 1, TG_A, 1);
        lu_pc = PC_P;
        #1 check("t4_old_miss", pred_hit, 0);
        lu_pc = PC_A;
        #1 check("t4_new_hit", pred_hit, 1);
        check("t4_new_target", pred_target, TG_A);
        check("t4_new_taken", pred_taken, 1);

        // Test 6a: invalidate beats a same-cycle taken write
        a_upd(32'h0040_0100, 1, 32'h0040_0200, 0);
        inv = 1;
        @(negedge clk); a_idle();
        #1 check("t6_inv_old_miss", pred_hit, 0);
        lu_pc = 32'h0040_0100;
        #1 check("t6_inv_new_miss", pred_hit, 0);
        check("t6_inv_cnt", mispred_cnt, 0);

        // Mispredict counting; an update with upd_valid=0 is ignored
        for (int i = 0; i < 3; i++) begin
            a_upd(32'h0040_0100, 0, 0, 1);
            @(negedge clk);
        end
        a_idle();
        #1 check("cnt_three", mispred_cnt, 3);
        upd_valid = 0; upd_pc = 32'h0040_0300; upd_taken = 1;
        upd_target = 32'h0040_0400; upd_mispredict = 1;
        @(negedge clk); a_idle();
        lu_pc = 32'h0040_0300;
        #1 check("ignored_upd_cnt", mispred_cnt, 3);
        check("ignored_upd_hit", pred_hit, 0);

        // Test 5: gshare history
        g_upd(PC_P, 1, TG_P, 6'd3, 0);          // BTB[4] valid, PHT[4^3=7] -> 2
        @(negedge clk);
        g_upd(PC_Q, 1, 32'h0040_0900, 6'b000001, 1); // repair -> ghr 000011
        @(negedge clk); g_idle();
        #1 check("t5_ghr_repair", g_pred_ghr, 6'b000011);
        check("t5_cnt1", g_mispred_cnt, 1);
        g_lu_valid = 1; g_lu_pc = PC_P;
        #1 check("t5_hit", g_pred_hit, 1);
        check("t5_taken", g_pred_taken, 1);
        check("t5_target", g_pred_target, TG_P);
        @(negedge clk);
        #1 check("t5_ghr_shift", g_pred_ghr, 6'b000111);
        check("t5_ghr7_hit", g_pred_hit, 1);
        g_upd(PC_Q, 0, 0, 6'b000101, 1);        // beats the lookup shift
        @(negedge clk); g_idle(); g_lu_valid = 0;
        #1 check("t5_ghr_priority", g_pred_ghr, 6'b001010);
        check("t5_cnt2", g_mispred_cnt, 2);
        for (int i = 0; i < 2; i++) begin
            g_upd(PC_Q, 0, 0, 6'd0, 1);
            @(negedge clk);
        end
        g_idle();
        #1 check("t6_cnt_sat", g_mispred_cnt, 3);

        // Test 6b: reset mid-stream clears outputs at once
        a_train(PC_P, 1, TG_P, 1);
        lu_pc = PC_P;
        #1 check("t6_pre_rst_hit", pred_hit, 1);
        reset = 0;
        #1;
        check("t6_rst_hit", pred_hit, 0);
        check("t6_rst_taken", pred_taken, 0);
        check("t6_rst_target", pred_target, 0);
        check("t6_rst_cnt", mispred_cnt, 0);
        check("t6_rst_g_ghr", g_pred_ghr, 0);
        check("t6_rst_g_cnt", g_mispred_cnt, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
